// File: rtl/seg7_pkg.sv
// Shared 7-segment glyph table (active-high, a=bit0) and the nibble decode helper.
package seg7_pkg;

  localparam logic [6:0] GLYPH_0     = 7'h3F;
  localparam logic [6:0] GLYPH_1     = 7'h06;
  localparam logic [6:0] GLYPH_2     = 7'h5B;
  localparam logic [6:0] GLYPH_3     = 7'h4F;
  localparam logic [6:0] GLYPH_4     = 7'h66;
  localparam logic [6:0] GLYPH_5     = 7'h6D;
  localparam logic [6:0] GLYPH_6     = 7'h7D;
  localparam logic [6:0] GLYPH_7     = 7'h07;
  localparam logic [6:0] GLYPH_8     = 7'h7F;
  localparam logic [6:0] GLYPH_9     = 7'h6F;
  localparam logic [6:0] GLYPH_A     = 7'h77;
  localparam logic [6:0] GLYPH_B     = 7'h7C;
  localparam logic [6:0] GLYPH_C     = 7'h39;
  localparam logic [6:0] GLYPH_D     = 7'h5E;
  localparam logic [6:0] GLYPH_E     = 7'h79;
  localparam logic [6:0] GLYPH_F     = 7'h71;
  localparam logic [6:0] GLYPH_BLANK = 7'h00;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    case (nibble)
      4'h0:    return GLYPH_0;
      4'h1:    return GLYPH_1;
      4'h2:    return GLYPH_2;
      4'h3:    return GLYPH_3;
      4'h4:    return GLYPH_4;
      4'h5:    return GLYPH_5;
      4'h6:    return GLYPH_6;
      4'h7:    return GLYPH_7;
      4'h8:    return GLYPH_8;
      4'h9:    return GLYPH_9;
      4'hA:    return GLYPH_A;
      4'hB:    return GLYPH_B;
      4'hC:    return GLYPH_C;
      4'hD:    return GLYPH_D;
      4'hE:    return GLYPH_E;
      default: return GLYPH_F;
    endcase
  endfunction

endpackage

// File: rtl/seg7_glyph_dec.sv
// Nibble to active-high 7-segment pattern; blank forces every segment off.
// Purely combinational (zero latency); no flow control.
module seg7_glyph_dec
  import seg7_pkg::*;
(
  input  logic [3:0] i_nibble,
  input  logic       i_blank,
  output logic [6:0] o_seg
);

  assign o_seg = i_blank ? GLYPH_BLANK : hex_to_seg(i_nibble);

endmodule

// File: rtl/seg7_mux_driver.sv
// Time-multiplexed N-digit 7-segment driver: dead-time scan, double-buffered load, LZ suppression.
// Pins lag scan state by 1 cycle; load is always accepted and shown from the next frame boundary.
module seg7_mux_driver
  import seg7_pkg::*;
#(
  parameter int N_DIGITS       = 4,
  parameter int CLK_DIV        = 50000,
  parameter int DEAD_CYCLES    = 2,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b1,
  parameter bit LZ_BLANK       = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*N_DIGITS-1:0]   value,
  input  logic [N_DIGITS-1:0]     dp_in,
  input  logic [N_DIGITS-1:0]     blank_in,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [N_DIGITS-1:0]     dig_sel,
  output logic                    frame_done,
  output logic                    pending
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [6:0]          SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic                DP_OFF  = SEG_ACTIVE_LOW;
  localparam logic [N_DIGITS-1:0] DIG_OFF = DIG_ACTIVE_LOW ? '1 : '0;

  logic [PW-1:0]         r_presc;
  logic [IW-1:0]         r_idx;
  logic [4*N_DIGITS-1:0] r_sh_val, r_ds_val;
  logic [N_DIGITS-1:0]   r_sh_dp, r_ds_dp;
  logic [N_DIGITS-1:0]   r_sh_blank, r_ds_blank;
  logic                  r_pending;
  logic [6:0]            r_seg;
  logic                  r_dp;
  logic [N_DIGITS-1:0]   r_dig;
  logic                  r_frame_done;

  logic                  w_slot_end, w_boundary, w_lit, w_lz_run;
  logic [3:0]            w_nibble;
  logic                  w_dp_req, w_dark;
  logic [N_DIGITS-1:0]   w_lz, w_onehot;
  logic [6:0]            w_glyph;

  assign w_slot_end = (r_presc == PW'(CLK_DIV - 1));
  assign w_boundary = enable && w_slot_end && (r_idx == IW'(N_DIGITS - 1));
  assign w_lit      = (r_presc >= PW'(DEAD_CYCLES));

  // Suppression runs from the top digit down and stops at the first nonzero or dp digit.
  always_comb begin
    w_lz     = '0;
    w_lz_run = LZ_BLANK;
    for (int i = N_DIGITS - 1; i > 0; i--) begin
      if (w_lz_run && (r_ds_val[4*i +: 4] == 4'h0) && !r_ds_dp[i])
        w_lz[i] = 1'b1;
      else
        w_lz_run = 1'b0;
    end
  end

  always_comb begin
    w_nibble = 4'h0;
    w_dp_req = 1'b0;
    w_dark   = 1'b1;
    w_onehot = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (r_idx == IW'(i)) begin
        w_nibble    = r_ds_val[4*i +: 4];
        w_dp_req    = r_ds_dp[i];
        w_dark      = r_ds_blank[i] | w_lz[i];
        w_onehot[i] = 1'b1;
      end
    end
  end

  seg7_glyph_dec u_glyph (
    .i_nibble (w_nibble),
    .i_blank  (w_dark),
    .o_seg    (w_glyph)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc      <= '0;
      r_idx        <= '0;
      r_seg        <= SEG_OFF;
      r_dp         <= DP_OFF;
      r_dig        <= DIG_OFF;
      r_frame_done <= 1'b0;
    end else if (!enable) begin
      r_presc      <= '0;
      r_idx        <= '0;
      r_seg        <= SEG_OFF;
      r_dp         <= DP_OFF;
      r_dig        <= DIG_OFF;
      r_frame_done <= 1'b0;
    end else begin
      r_presc <= w_slot_end ? '0 : r_presc + 1'b1;
      if (w_slot_end)
        r_idx <= (r_idx == IW'(N_DIGITS - 1)) ? '0 : r_idx + 1'b1;
      r_frame_done <= w_boundary;
      if (w_lit) begin
        r_seg <= SEG_ACTIVE_LOW ? ~w_glyph : w_glyph;
        r_dp  <= (w_dp_req & ~w_dark) ^ SEG_ACTIVE_LOW;
        r_dig <= DIG_ACTIVE_LOW ? ~w_onehot : w_onehot;
      end else begin
        r_seg <= SEG_OFF;
        r_dp  <= DP_OFF;
        r_dig <= DIG_OFF;
      end
    end
  end

  // The boundary transfer reads the old shadow, so a coincident load waits one more frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh_val   <= '0;
      r_sh_dp    <= '0;
      r_sh_blank <= '1;
      r_ds_val   <= '0;
      r_ds_dp    <= '0;
      r_ds_blank <= '1;
      r_pending  <= 1'b0;
    end else begin
      if (w_boundary && r_pending) begin
        r_ds_val   <= r_sh_val;
        r_ds_dp    <= r_sh_dp;
        r_ds_blank <= r_sh_blank;
      end
      if (load) begin
        r_sh_val   <= value;
        r_sh_dp    <= dp_in;
        r_sh_blank <= blank_in;
        r_pending  <= 1'b1;
      end else if (w_boundary) begin
        r_pending  <= 1'b0;
      end
    end
  end

  assign seg        = r_seg;
  assign dp         = r_dp;
  assign dig_sel    = r_dig;
  assign frame_done = r_frame_done;
  assign pending    = r_pending;

endmodule

// File: tb/tb_seg7_mux_driver.sv
// Bench for seg7_mux_driver: per-cycle scoreboard fed by a slot-arithmetic reference model,
// plus directed frame captures; two DUTs (LZ off / LZ on) share all stimulus.
module tb_seg7_mux_driver;

  localparam int N  = 4;
  localparam int CD = 8;
  localparam int DC = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blank_in = '0;

  logic [6:0] seg, seg_lz;
  logic       dp, dp_lz;
  logic [3:0] dig_sel, dig_sel_lz;
  logic       frame_done, frame_done_lz, pending, pending_lz;

  always #5 clk = ~clk;

  seg7_mux_driver #(.N_DIGITS(N), .CLK_DIV(CD), .DEAD_CYCLES(DC),
                    .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1), .LZ_BLANK(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .value(value),
    .dp_in(dp_in), .blank_in(blank_in), .seg(seg), .dp(dp), .dig_sel(dig_sel),
    .frame_done(frame_done), .pending(pending));

  seg7_mux_driver #(.N_DIGITS(N), .CLK_DIV(CD), .DEAD_CYCLES(DC),
                    .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1), .LZ_BLANK(1'b1)) dut_lz (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .value(value),
    .dp_in(dp_in), .blank_in(blank_in), .seg(seg_lz), .dp(dp_lz), .dig_sel(dig_sel_lz),
    .frame_done(frame_done_lz), .pending(pending_lz));

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, want, $time);
    end
  endtask

  logic [6:0] glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  typedef struct packed {
    logic [6:0] seg;
    logic [6:0] seg_lz;
    logic       dp;
    logic       dp_lz;
    logic [3:0] dig;
    logic       fd;
    logic       pend;
  } exp_t;

  exp_t q[$];

  // Reference model: position in the scan is derived from cycles elapsed since enable.
  int   m_t, m_pos, m_d;
  int   m_dv[N], m_ddp[N], m_dbl[N], m_sv[N], m_sdp[N], m_sbl[N];
  bit   m_pend, m_fd, m_dark, m_dark_lz;
  exp_t m_e;

  function automatic bit lz_sup(input int d);
    if (d == 0) return 1'b0;
    for (int k = d; k < N; k++)
      if (m_dv[k] != 0 || m_ddp[k] != 0) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_t = 0;
      m_pend = 1'b0;
      q.delete();
      for (int k = 0; k < N; k++) begin
        m_dv[k] = 0; m_ddp[k] = 0; m_dbl[k] = 1;
        m_sv[k] = 0; m_sdp[k] = 0; m_sbl[k] = 1;
      end
    end else begin
      m_e = '{seg: 7'h7F, seg_lz: 7'h7F, dp: 1'b1, dp_lz: 1'b1, dig: 4'hF, fd: 1'b0, pend: 1'b0};
      m_fd = 1'b0;
      if (enable) begin
        m_pos = m_t % CD;
        m_d   = (m_t / CD) % N;
        m_fd  = (m_pos == CD - 1) && (m_d == N - 1);
        if (m_pos >= DC) begin
          m_dark    = (m_dbl[m_d] != 0);
          m_dark_lz = m_dark || lz_sup(m_d);
          m_e.dig    = ~(4'b0001 << m_d);
          m_e.seg    = m_dark    ? 7'h7F : ~glyph_tab[m_dv[m_d]];
          m_e.seg_lz = m_dark_lz ? 7'h7F : ~glyph_tab[m_dv[m_d]];
          m_e.dp     = !((m_ddp[m_d] != 0) && !m_dark);
          m_e.dp_lz  = !((m_ddp[m_d] != 0) && !m_dark_lz);
        end
        m_t++;
      end else begin
        m_t = 0;
      end
      if (m_fd && m_pend) begin
        for (int k = 0; k < N; k++) begin
          m_dv[k] = m_sv[k]; m_ddp[k] = m_sdp[k]; m_dbl[k] = m_sbl[k];
        end
        m_pend = 1'b0;
      end
      if (load) begin
        for (int k = 0; k < N; k++) begin
          m_sv[k] = int'(value[4*k +: 4]); m_sdp[k] = int'(dp_in[k]); m_sbl[k] = int'(blank_in[k]);
        end
        m_pend = 1'b1;
      end
      m_e.fd   = m_fd;
      m_e.pend = m_pend;
      q.push_back(m_e);
    end
  end

  exp_t mon_e;
  always @(negedge clk) begin
    if (rst_n && q.size() > 0) begin
      mon_e = q.pop_front();
      chk("sb_pins", {seg, dp, dig_sel, frame_done, pending},
          {mon_e.seg, mon_e.dp, mon_e.dig, mon_e.fd, mon_e.pend});
      chk("sb_pins_lz", {seg_lz, dp_lz, dig_sel_lz, frame_done_lz, pending_lz},
          {mon_e.seg_lz, mon_e.dp_lz, mon_e.dig, mon_e.fd, mon_e.pend});
    end
  end

  // Directed frame capture: last seg/dp seen per digit across one 32-cycle frame.
  int         cnt[N];
  int         fdn;
  logic [6:0] sg[N], sgl[N];
  logic       dpv[N], dpl[N];

  task automatic collect();
    fdn = 0;
    for (int d = 0; d < N; d++) begin
      cnt[d] = 0; sg[d] = '0; sgl[d] = '0; dpv[d] = 1'b0; dpl[d] = 1'b0;
    end
    for (int c = 0; c < N * CD; c++) begin
      @(negedge clk);
      if (frame_done) fdn++;
      for (int d = 0; d < N; d++) begin
        if (dig_sel == ~(4'b0001 << d)) begin
          cnt[d]++; sg[d] = seg; dpv[d] = dp;
        end
        if (dig_sel_lz == ~(4'b0001 << d)) begin
          sgl[d] = seg_lz; dpl[d] = dp_lz;
        end
      end
    end
  endtask

  task automatic wait_fd();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!frame_done && k < 100);
    chk("fd_wait", frame_done, 1'b1);
  endtask

  task automatic pulse_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
    value = v; dp_in = d; blank_in = b; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  initial begin
    int k;
    #12;
    chk("rst_pins", {seg, dp, dig_sel, frame_done, pending}, {7'h7F, 1'b1, 4'hF, 1'b0, 1'b0});
    chk("rst_pins_lz", {seg_lz, dp_lz, dig_sel_lz, frame_done_lz, pending_lz},
        {7'h7F, 1'b1, 4'hF, 1'b0, 1'b0});
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_pins", {seg, dp, dig_sel, frame_done}, {7'h7F, 1'b1, 4'hF, 1'b0});

    // Blank display after reset: every slot dark, 7 of 8 cycles selected.
    enable = 1'b1;
    wait_fd();
    collect();
    chk("t1_cnt", {8'(cnt[3]), 8'(cnt[2]), 8'(cnt[1]), 8'(cnt[0])}, {4{8'd7}});
    chk("t1_seg", {sg[3], sg[2], sg[1], sg[0]}, {4{7'h7F}});
    chk("t1_dp", {dpv[3], dpv[2], dpv[1], dpv[0]}, 4'hF);
    chk("t1_fd_once", fdn, 1);
    chk("t1_fd_end", frame_done, 1'b1);

    pulse_load(16'h12F0, 4'b0100, 4'h0);
    chk("t2_pend_set", pending, 1'b1);
    wait_fd();
    collect();
    chk("t2_seg", {sg[3], sg[2], sg[1], sg[0]}, {7'h79, 7'h24, 7'h0E, 7'h40});
    chk("t2_dp", {dpv[3], dpv[2], dpv[1], dpv[0]}, 4'b1011);
    chk("t2_pend_clr", pending, 1'b0);

    // Two loads mid-frame, a third on the boundary cycle itself.
    repeat (3) @(negedge clk);
    pulse_load(16'h1111, 4'h0, 4'h0);
    repeat (5) @(negedge clk);
    pulse_load(16'h2222, 4'h0, 4'h0);
    repeat (21) @(negedge clk);
    pulse_load(16'h3333, 4'h0, 4'h0);
    chk("t3_fd_align", frame_done, 1'b1);
    chk("t3_pend_kept", pending, 1'b1);
    collect();
    chk("t3_seg_2222", {sg[3], sg[2], sg[1], sg[0]}, {4{7'h24}});
    collect();
    chk("t3_seg_3333", {sg[3], sg[2], sg[1], sg[0]}, {4{7'h30}});
    chk("t3_pend_clr", pending, 1'b0);

    pulse_load(16'h0070, 4'h0, 4'h0);
    wait_fd();
    collect();
    chk("t4_seg", {sg[3], sg[2], sg[1], sg[0]}, {7'h40, 7'h40, 7'h78, 7'h40});
    chk("t4_seg_lz", {sgl[3], sgl[2], sgl[1], sgl[0]}, {7'h7F, 7'h7F, 7'h78, 7'h40});
    pulse_load(16'h0000, 4'h0, 4'h0);
    wait_fd();
    collect();
    chk("t4_zero_lz", {sgl[3], sgl[2], sgl[1], sgl[0]}, {7'h7F, 7'h7F, 7'h7F, 7'h40});
    chk("t4_zero_dp_lz", {dpl[3], dpl[2], dpl[1], dpl[0]}, 4'hF);

    // Drop enable inside digit 2's slot, then restart.
    k = 0;
    while (dig_sel != 4'hB && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("t5_find_d2", dig_sel, 4'hB);
    repeat (2) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    chk("t5_off", {seg, dp, dig_sel, frame_done}, {7'h7F, 1'b1, 4'hF, 1'b0});
    chk("t5_off_lz", dig_sel_lz, 4'hF);
    pulse_load(16'h5678, 4'h1, 4'h0);
    chk("t5_load_off", pending, 1'b1);
    repeat (3) @(negedge clk);
    enable = 1'b1;
    k = 0;
    @(negedge clk);
    while (dig_sel == 4'hF && k < 20) begin
      k++;
      @(negedge clk);
    end
    chk("t5_dead", k, 1);
    chk("t5_first_d0", dig_sel, 4'hE);

    // Asynchronous reset between clock edges.
    repeat (13) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_arst", {seg, dp, dig_sel, frame_done, pending}, {7'h7F, 1'b1, 4'hF, 1'b0, 1'b0});
    chk("t6_arst_lz", {seg_lz, dig_sel_lz, pending_lz}, {7'h7F, 4'hF, 1'b0});
    @(negedge clk); rst_n = 1'b1;

    for (int c = 0; c < 900; c++) begin
      @(negedge clk);
      load = 1'b0;
      if ($urandom_range(0, 99) < 12) begin
        value = 16'($urandom);
        for (int n = 0; n < N; n++)
          if ($urandom_range(0, 1) == 1) value[4*n +: 4] = 4'h0;
        dp_in    = 4'($urandom & $urandom & $urandom);
        blank_in = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
        load     = 1'b1;
      end
      if (enable && $urandom_range(0, 199) == 0) enable = 1'b0;
      else if (!enable && $urandom_range(0, 7) == 0) enable = 1'b1;
    end
    @(negedge clk); load = 1'b0;
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
